// File: rtl/ysyx_23060203_pkg.sv
// Shared types and constants for the posted-write store buffer.
package ysyx_23060203_pkg;

  localparam int STBUF_AW = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_SIZE_B = 3'd0;
  localparam logic [2:0] AXI_SIZE_H = 3'd1;
  localparam logic [2:0] AXI_SIZE_W = 3'd2;

  typedef struct packed {
    logic [STBUF_AW-1:0] addr;
    logic [31:0]         data;
    logic [3:0]          strb;
  } stbuf_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2
  } stbuf_state_t;

  // Irregular strobe patterns fall back to a full word; the strobes still mask the bytes.
  function automatic logic [2:0] strb_to_size(input logic [3:0] strb);
    case (strb)
      4'b1111:                         strb_to_size = AXI_SIZE_W;
      4'b0011, 4'b1100:                strb_to_size = AXI_SIZE_H;
      4'b0001, 4'b0010,
      4'b0100, 4'b1000:                strb_to_size = AXI_SIZE_B;
      default:                         strb_to_size = AXI_SIZE_W;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060203_stbuf_fifo.sv
// In-order entry storage for the store buffer, plus an age-ordered view
// (index 0 = head) used by the load-conflict compare.
module ysyx_23060203_stbuf_fifo
  import ysyx_23060203_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_push,
  input  stbuf_entry_t            i_push_entry,
  input  logic                    i_pop,
  output stbuf_entry_t            o_head,
  output logic                    o_full,
  output logic                    o_nonempty,
  output logic [DEPTH-1:0]        o_view_valid,
  output logic [STBUF_AW-1:2]     o_view_word [DEPTH]
`ifdef YSYX_23060203_STBUF_FWD_EN
  ,
  output logic [31:0]             o_view_data [DEPTH],
  output logic [3:0]              o_view_strb [DEPTH]
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  stbuf_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_push) r_mem[r_tail] <= i_push_entry;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head     = r_mem[r_head];
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_nonempty = (r_count != '0);

  // Rotate so that view slot i is the i-th oldest entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_view_valid[i] = (CW'(i) < r_count);
      o_view_word[i]  = r_mem[r_head + PW'(i)].addr[STBUF_AW-1:2];
`ifdef YSYX_23060203_STBUF_FWD_EN
      o_view_data[i]  = r_mem[r_head + PW'(i)].data;
      o_view_strb[i]  = r_mem[r_head + PW'(i)].strb;
`endif
    end
  end

endmodule

// File: rtl/ysyx_23060203_store_buffer.sv
// Posted-write store buffer: queues EXU stores and drains them as single-beat AXI4 writes.
// Optional load forwarding of full-word matches: define YSYX_23060203_STBUF_FWD_EN.
//
//   state | meaning
//   IDLE  | no write in flight; start one when the FIFO holds an entry
//   SEND  | head driven on AW and W; each valid drops after its own handshake
//   RESP  | both handshakes done; wait for B, then pop the head
module ysyx_23060203_store_buffer
  import ysyx_23060203_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = STBUF_AW
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [AW-1:0] i_in_addr,
  input  logic [31:0]   i_in_data,
  input  logic [3:0]    i_in_strb,
  input  logic [AW-1:0] i_chk_addr,
  output logic          o_chk_conflict,
`ifdef YSYX_23060203_STBUF_FWD_EN
  output logic          o_chk_fwd_valid,
  output logic [31:0]   o_chk_fwd_data,
`endif
  output logic          o_empty,
  output logic          o_err,
  output logic          o_awvalid,
  input  logic          i_awready,
  output logic [AW-1:0] o_awaddr,
  output logic [2:0]    o_awsize,
  output logic          o_wvalid,
  input  logic          i_wready,
  output logic [31:0]   o_wdata,
  output logic [3:0]    o_wstrb,
  output logic          o_wlast,
  input  logic          i_bvalid,
  output logic          o_bready,
  input  logic [1:0]    i_bresp
);

  stbuf_state_t r_state;
  stbuf_state_t w_state_next;
  logic         r_aw_done;
  logic         r_w_done;
  logic         r_err;

  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_nonempty;
  logic         w_aw_hs;
  logic         w_w_hs;
  logic         w_resp_ok;
  logic         w_hit;
  logic         w_unused;
  stbuf_entry_t w_head;
  stbuf_entry_t w_push_entry;
  logic [DEPTH-1:0]    w_view_valid;
  logic [STBUF_AW-1:2] w_view_word [DEPTH];
`ifdef YSYX_23060203_STBUF_FWD_EN
  logic [31:0]  w_view_data [DEPTH];
  logic [3:0]   w_view_strb [DEPTH];
  logic         w_hit_full;
  logic [31:0]  w_hit_data;
`endif

  assign w_push_entry = '{addr: STBUF_AW'(i_in_addr), data: i_in_data, strb: i_in_strb};
  assign o_in_ready   = !w_full;
  assign w_push       = i_in_valid && o_in_ready;

  ysyx_23060203_stbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_nonempty   (w_nonempty),
    .o_view_valid (w_view_valid),
    .o_view_word  (w_view_word)
`ifdef YSYX_23060203_STBUF_FWD_EN
    ,
    .o_view_data  (w_view_data),
    .o_view_strb  (w_view_strb)
`endif
  );

  assign o_awvalid = (r_state == SEND) && !r_aw_done;
  assign o_wvalid  = (r_state == SEND) && !r_w_done;
  assign o_bready  = (r_state == RESP);
  assign w_aw_hs   = o_awvalid && i_awready;
  assign w_w_hs    = o_wvalid && i_wready;
  assign w_pop     = o_bready && i_bvalid;
  assign w_resp_ok = (i_bresp == AXI_RESP_OKAY) || (i_bresp == AXI_RESP_EXOKAY);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_nonempty) w_state_next = SEND;
      SEND:    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_next = RESP;
      RESP:    if (i_bvalid) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_pop && !w_resp_ok;
      if (w_state_next != SEND) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
    end
  end

  // The head stays buffered until B, so the outstanding write is always the head entry.
  assign o_awaddr = AW'(w_head.addr);
  assign o_awsize = strb_to_size(w_head.strb);
  assign o_wdata  = w_head.data;
  assign o_wstrb  = w_head.strb;
  assign o_wlast  = 1'b1;
  assign o_empty  = !w_nonempty && (r_state == IDLE);
  assign o_err    = r_err;

  // View is oldest-first, so the last match in the loop is the youngest one.
  always_comb begin
    w_hit = 1'b0;
`ifdef YSYX_23060203_STBUF_FWD_EN
    w_hit_full = 1'b0;
    w_hit_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (w_view_valid[i] && (w_view_word[i] == i_chk_addr[AW-1:2])) begin
        w_hit = 1'b1;
`ifdef YSYX_23060203_STBUF_FWD_EN
        w_hit_full = (w_view_strb[i] == 4'b1111);
        w_hit_data = w_view_data[i];
`endif
      end
    end
  end

`ifdef YSYX_23060203_STBUF_FWD_EN
  assign o_chk_fwd_valid = w_hit_full;
  assign o_chk_fwd_data  = w_hit_data;
  assign o_chk_conflict  = w_hit && !w_hit_full;
`else
  assign o_chk_conflict  = w_hit;
`endif

  // Byte offset within the word never affects the conflict decision.
  assign w_unused = ^i_chk_addr[1:0];

endmodule
